// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the reg-reg ALU control sequencer: states, opcodes,
// IR field positions, fault codes and the strobe bundle.
package cpu_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_T0   = 3'd1,
    ST_T1   = 3'd2,
    ST_T2   = 3'd3,
    ST_T3   = 3'd4,
    ST_T4   = 3'd5,
    ST_T5   = 3'd6,
    ST_T6   = 3'd7
  } state_t;

  localparam logic [4:0] OP_ADD = 5'b00011;
  localparam logic [4:0] OP_SUB = 5'b00100;
  localparam logic [4:0] OP_AND = 5'b00101;
  localparam logic [4:0] OP_OR  = 5'b00110;
  localparam logic [4:0] OP_SHL = 5'b00111;
  localparam logic [4:0] OP_SHR = 5'b01000;
  localparam logic [4:0] OP_ROR = 5'b01001;
  localparam logic [4:0] OP_ROL = 5'b01010;
  localparam logic [4:0] OP_MUL = 5'b01111;
  localparam logic [4:0] OP_DIV = 5'b10000;
  localparam logic [4:0] OP_NEG = 5'b10001;
  localparam logic [4:0] OP_NOT = 5'b10010;

  localparam int IR_OP_MSB = 31;
  localparam int IR_OP_LSB = 27;
  localparam int IR_RA_MSB = 26;
  localparam int IR_RA_LSB = 23;
  localparam int IR_RB_MSB = 22;
  localparam int IR_RB_LSB = 19;
  localparam int IR_RC_MSB = 18;
  localparam int IR_RC_LSB = 15;

  localparam logic [1:0] FAULT_NONE    = 2'b00;
  localparam logic [1:0] FAULT_ILLEGAL = 2'b01;
  localparam logic [1:0] FAULT_TIMEOUT = 2'b10;

  typedef struct packed {
    logic PCout;
    logic MARin;
    logic IncPC;
    logic Zin;
    logic Zlowout;
    logic Zhighout;
    logic PCin;
    logic Read;
    logic MDRin;
    logic MDRout;
    logic IRin;
    logic Yin;
    logic HIin;
    logic LOin;
  } strobes_t;

  function automatic logic is_legal_op(input logic [4:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHL, OP_SHR, OP_ROR, OP_ROL,
      OP_MUL, OP_DIV, OP_NEG, OP_NOT: return 1'b1;
      default:                        return 1'b0;
    endcase
  endfunction

  function automatic logic is_muldiv(input logic [4:0] op);
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

  function automatic logic is_unary(input logic [4:0] op);
    return (op == OP_NEG) || (op == OP_NOT);
  endfunction

endpackage

// File: rtl/alu_ctrl_sequencer_if.sv
// Handshake and strobe bundle between the control sequencer (slave side)
// and the datapath/driver (master side).
interface alu_ctrl_sequencer_if;
  logic        run;
  logic        mem_ready;
  logic [31:0] IR;
  logic        PCout, MARin, IncPC, Zin, Zlowout, Zhighout;
  logic        PCin, Read, MDRin, MDRout, IRin, Yin, HIin, LOin;
  logic [15:0] Rin;
  logic [15:0] Rout;
  logic [4:0]  opcode;
  logic        done;
  logic [1:0]  fault;

  modport master (
    output run, mem_ready, IR,
    input  PCout, MARin, IncPC, Zin, Zlowout, Zhighout,
    input  PCin, Read, MDRin, MDRout, IRin, Yin, HIin, LOin,
    input  Rin, Rout, opcode, done, fault
  );

  modport slave (
    input  run, mem_ready, IR,
    output PCout, MARin, IncPC, Zin, Zlowout, Zhighout,
    output PCin, Read, MDRin, MDRout, IRin, Yin, HIin, LOin,
    output Rin, Rout, opcode, done, fault
  );
endinterface

// File: rtl/reg_field_decoder.sv
// 4-bit register index to 16-bit one-hot enable; all zero when en is low.
module reg_field_decoder (
  input  logic [3:0]  idx,
  input  logic        en,
  output logic [15:0] onehot
);
  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_bit
      assign onehot[gi] = en && (idx == 4'(gi));
    end
  endgenerate
endmodule

// File: rtl/alu_ctrl_sequencer.sv
// Fetch/execute control-step sequencer for reg-reg ALU instructions.
// Every output is registered from the next-state decode so it lines up with its state.
module alu_ctrl_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int MEM_WAIT_MAX = 16
) (
  input logic                 Clock,
  input logic                 clear,
  alu_ctrl_sequencer_if.slave bus
);
  localparam int CW = $clog2(MEM_WAIT_MAX + 1);
  localparam logic [CW-1:0] STALL_LAST = CW'(MEM_WAIT_MAX - 1);

  state_t        state_reg, state_next;
  logic [CW-1:0] stall_reg, stall_next;
  logic [1:0]    fault_reg, fault_next;
  strobes_t      strb_reg, strb_next;
  logic [15:0]   rin_reg, rin_next, rout_reg, rout_next;
  logic [4:0]    opcode_reg, opcode_next;
  logic          done_reg, done_next;
  logic          rin_en, rout_en;
  logic [3:0]    rout_idx;

  logic [4:0] ir_op;
  logic [3:0] ir_ra, ir_rb, ir_rc;
  logic       op_legal, op_muldiv, op_unary;
  logic       ir_unused;

  assign ir_op     = bus.IR[IR_OP_MSB:IR_OP_LSB];
  assign ir_ra     = bus.IR[IR_RA_MSB:IR_RA_LSB];
  assign ir_rb     = bus.IR[IR_RB_MSB:IR_RB_LSB];
  assign ir_rc     = bus.IR[IR_RC_MSB:IR_RC_LSB];
  assign ir_unused = ^bus.IR[IR_RC_LSB-1:0];
  assign op_legal  = is_legal_op(ir_op);
  assign op_muldiv = is_muldiv(ir_op);
  assign op_unary  = is_unary(ir_op);

  always_comb begin
    state_next  = state_reg;
    stall_next  = '0;
    fault_next  = fault_reg;
    done_next   = 1'b0;
    strb_next   = '0;
    opcode_next = '0;
    rin_en      = 1'b0;
    rout_en     = 1'b0;
    rout_idx    = ir_rb;

    case (state_reg)
      ST_IDLE: if (bus.run) begin
        state_next = ST_T0;
        fault_next = FAULT_NONE;
      end
      ST_T0: state_next = ST_T1;
      ST_T1: begin
        if (bus.mem_ready) begin
          state_next = ST_T2;
        end else if (stall_reg == STALL_LAST) begin
          state_next = ST_IDLE;
          fault_next = FAULT_TIMEOUT;
        end else begin
          stall_next = stall_reg + CW'(1);
        end
      end
      ST_T2: state_next = ST_T3;
      ST_T3: begin
        if (op_legal) begin
          state_next = ST_T4;
        end else begin
          state_next = ST_IDLE;
          fault_next = FAULT_ILLEGAL;
        end
      end
      ST_T4: state_next = ST_T5;
      ST_T5: begin
        state_next = op_muldiv ? ST_T6 : ST_IDLE;
        done_next  = !op_muldiv;
      end
      ST_T6: begin
        state_next = ST_IDLE;
        done_next  = 1'b1;
      end
      default: state_next = ST_IDLE;
    endcase

    // Strobes for the state being entered; PC update happens only on T1 entry.
    case (state_next)
      ST_T0: begin
        strb_next.PCout = 1'b1;
        strb_next.MARin = 1'b1;
        strb_next.IncPC = 1'b1;
        strb_next.Zin   = 1'b1;
      end
      ST_T1: begin
        strb_next.Read    = 1'b1;
        strb_next.MDRin   = 1'b1;
        strb_next.PCin    = (state_reg == ST_T0);
        strb_next.Zlowout = (state_reg == ST_T0);
      end
      ST_T2: begin
        strb_next.MDRout = 1'b1;
        strb_next.IRin   = 1'b1;
      end
      ST_T3: begin
        // An illegal instruction spends its T3 cycle with every strobe low.
        rout_en       = op_legal;
        strb_next.Yin = op_legal;
      end
      ST_T4: begin
        rout_en       = 1'b1;
        rout_idx      = op_unary ? ir_rb : ir_rc;
        opcode_next   = ir_op;
        strb_next.Zin = 1'b1;
      end
      ST_T5: begin
        strb_next.Zlowout = 1'b1;
        strb_next.LOin    = op_muldiv;
        rin_en            = !op_muldiv;
      end
      ST_T6: begin
        strb_next.Zhighout = 1'b1;
        strb_next.HIin     = 1'b1;
      end
      default: ;
    endcase
  end

  reg_field_decoder u_rin_dec (
    .idx    (ir_ra),
    .en     (rin_en),
    .onehot (rin_next)
  );

  reg_field_decoder u_rout_dec (
    .idx    (rout_idx),
    .en     (rout_en),
    .onehot (rout_next)
  );

  always_ff @(posedge Clock or negedge clear) begin
    if (!clear) begin
      state_reg  <= ST_IDLE;
      stall_reg  <= '0;
      fault_reg  <= FAULT_NONE;
      strb_reg   <= '0;
      rin_reg    <= '0;
      rout_reg   <= '0;
      opcode_reg <= '0;
      done_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      stall_reg  <= stall_next;
      fault_reg  <= fault_next;
      strb_reg   <= strb_next;
      rin_reg    <= rin_next;
      rout_reg   <= rout_next;
      opcode_reg <= opcode_next;
      done_reg   <= done_next;
    end
  end

  assign bus.PCout    = strb_reg.PCout;
  assign bus.MARin    = strb_reg.MARin;
  assign bus.IncPC    = strb_reg.IncPC;
  assign bus.Zin      = strb_reg.Zin;
  assign bus.Zlowout  = strb_reg.Zlowout;
  assign bus.Zhighout = strb_reg.Zhighout;
  assign bus.PCin     = strb_reg.PCin;
  assign bus.Read     = strb_reg.Read;
  assign bus.MDRin    = strb_reg.MDRin;
  assign bus.MDRout   = strb_reg.MDRout;
  assign bus.IRin     = strb_reg.IRin;
  assign bus.Yin      = strb_reg.Yin;
  assign bus.HIin     = strb_reg.HIin;
  assign bus.LOin     = strb_reg.LOin;
  assign bus.Rin      = rin_reg;
  assign bus.Rout     = rout_reg;
  assign bus.opcode   = opcode_reg;
  assign bus.done     = done_reg;
  assign bus.fault    = fault_reg;

endmodule

// File: tb/tb_alu_ctrl_sequencer.sv
// Directed bench for alu_ctrl_sequencer: per-cycle strobe logs checked against
// hand-computed values for fetch, execute, stalls, faults and async clear.
module tb_alu_ctrl_sequencer;
  logic Clock = 1'b0;
  logic clear;
  int   checks   = 0;
  int   failures = 0;

  alu_ctrl_sequencer_if bus();

  alu_ctrl_sequencer #(.MEM_WAIT_MAX(16)) dut (
    .Clock (Clock),
    .clear (clear),
    .bus   (bus)
  );

  always #5 Clock = ~Clock;

  // Strobe vector order: PCout MARin IncPC Zin Zlowout Zhighout PCin Read MDRin MDRout IRin Yin HIin LOin
  logic [13:0] strb_now;
  assign strb_now = {bus.PCout, bus.MARin, bus.IncPC, bus.Zin, bus.Zlowout, bus.Zhighout,
                     bus.PCin, bus.Read, bus.MDRin, bus.MDRout, bus.IRin, bus.Yin,
                     bus.HIin, bus.LOin};

  logic [13:0] strb_log [64];
  logic [15:0] rin_log  [64];
  logic [15:0] rout_log [64];
  logic [4:0]  op_log   [64];
  logic [1:0]  fault_log[64];
  logic        done_log [64];
  int          done_at, fault_at, read_cnt, pcin_cnt, rin_hits;
  logic        onehot_bad;

  function automatic logic [31:0] mk_ir(input logic [4:0] op, input logic [3:0] a,
                                        input logic [3:0] b, input logic [3:0] c);
    return {op, a, b, c, 15'd0};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  // Issue one instruction from IDLE; k counts edges from the one that samples run.
  task automatic run_instr(input logic [31:0] ir, input int ready_delay,
                           input int run_len, input int max_cyc);
    done_at = 0; fault_at = 0; read_cnt = 0; pcin_cnt = 0; rin_hits = 0;
    onehot_bad = 1'b0;
    for (int i = 0; i < 64; i++) begin
      strb_log[i] = '0; rin_log[i] = '0; rout_log[i] = '0;
      op_log[i] = '0; fault_log[i] = '0; done_log[i] = 1'b0;
    end
    bus.IR = ir;
    bus.run = 1'b1;
    bus.mem_ready = 1'b0;
    for (int k = 1; k <= max_cyc; k++) begin
      @(posedge Clock);
      #1;
      if (k >= run_len) bus.run = 1'b0;
      bus.mem_ready = (k >= 2 + ready_delay);
      strb_log[k] = strb_now; rin_log[k] = bus.Rin; rout_log[k] = bus.Rout;
      op_log[k] = bus.opcode; fault_log[k] = bus.fault; done_log[k] = bus.done;
      if (bus.Read) read_cnt++;
      if (bus.PCin) pcin_cnt++;
      if (bus.Rin != 16'h0) rin_hits++;
      if ($countones(bus.Rin) > 1 || $countones(bus.Rout) > 1) onehot_bad = 1'b1;
      if (bus.done && done_at == 0) done_at = k;
      if (bus.fault != 2'b00 && fault_at == 0) fault_at = k;
      if (done_at != 0 || fault_at != 0) break;
    end
  endtask

  initial begin
    bus.run = 1'b0;
    bus.mem_ready = 1'b0;
    bus.IR = 32'h0;
    clear = 1'b0;
    #1;
    chk("reset_strobes", 32'(strb_now), 32'h0);
    chk("reset_rin_rout", {bus.Rin, bus.Rout}, 32'h0);
    chk("reset_op_done_fault", {24'h0, bus.opcode, bus.done, bus.fault}, 32'h0);
    repeat (2) @(posedge Clock);
    #1;
    clear = 1'b1;

    // shl R1,R2,R3
    run_instr(32'h3891_8000, 0, 1, 20);
    chk("shl_t0", 32'(strb_log[1]), 32'h3C00);
    chk("shl_t1", 32'(strb_log[2]), 32'h02E0);
    chk("shl_t2", 32'(strb_log[3]), 32'h0018);
    chk("shl_t3_strb", 32'(strb_log[4]), 32'h0004);
    chk("shl_t3_rout", 32'(rout_log[4]), 32'h0004);
    chk("shl_t3_op", 32'(op_log[4]), 32'h0);
    chk("shl_t4_rout", 32'(rout_log[5]), 32'h0008);
    chk("shl_t4_op", 32'(op_log[5]), 32'h07);
    chk("shl_t4_strb", 32'(strb_log[5]), 32'h0400);
    chk("shl_t5_rin", 32'(rin_log[6]), 32'h0002);
    chk("shl_t5_strb", 32'(strb_log[6]), 32'h0200);
    chk("shl_done_at", 32'(done_at), 32'd7);
    chk("shl_onehot", 32'(onehot_bad), 32'h0);

    // neg R2,R9,R3 issued back-to-back in the done cycle
    run_instr(mk_ir(5'b10001, 4'd2, 4'd9, 4'd3), 0, 1, 20);
    chk("b2b_t0", 32'(strb_log[1]), 32'h3C00);
    chk("b2b_done_low", 32'(done_log[1]), 32'h0);
    chk("neg_t4_rout", 32'(rout_log[5]), 32'h0200);
    chk("neg_t4_op", 32'(op_log[5]), 32'h11);
    chk("neg_t5_rin", 32'(rin_log[6]), 32'h0004);
    chk("neg_done_at", 32'(done_at), 32'd7);

    // add R5,R6,R7 with mem_ready low for 3 T1 cycles
    run_instr(mk_ir(5'b00011, 4'd5, 4'd6, 4'd7), 3, 1, 30);
    chk("stall_read_cycles", 32'(read_cnt), 32'd4);
    chk("stall_pcin_cycles", 32'(pcin_cnt), 32'd1);
    chk("stall_t1_hold", 32'(strb_log[3]), 32'h0060);
    chk("stall_t5_rin", 32'(rin_log[9]), 32'h0020);
    chk("stall_done_at", 32'(done_at), 32'd10);

    // mul R0,R4,R5 with run held high into fetch (must be ignored)
    run_instr(mk_ir(5'b01111, 4'd0, 4'd4, 4'd5), 0, 4, 20);
    chk("mul_t4_op", 32'(op_log[5]), 32'h0F);
    chk("mul_t4_rout", 32'(rout_log[5]), 32'h0020);
    chk("mul_t5_strb", 32'(strb_log[6]), 32'h0201);
    chk("mul_t5_rin", 32'(rin_log[6]), 32'h0);
    chk("mul_t6_strb", 32'(strb_log[7]), 32'h0102);
    chk("mul_done_at", 32'(done_at), 32'd8);
    repeat (2) @(posedge Clock);
    #1;

    // illegal opcode 11111
    run_instr(mk_ir(5'b11111, 4'd4, 4'd1, 4'd2), 0, 1, 20);
    chk("ill_t3_strb", 32'(strb_log[4]), 32'h0);
    chk("ill_t3_rout", 32'(rout_log[4]), 32'h0);
    chk("ill_fault_at", 32'(fault_at), 32'd5);
    chk("ill_fault_code", 32'(fault_log[5]), 32'h1);
    chk("ill_rin_hits", 32'(rin_hits), 32'd0);
    chk("ill_no_done", 32'(done_at), 32'd0);
    repeat (2) @(posedge Clock);
    #1;
    chk("ill_fault_sticky", 32'(bus.fault), 32'h1);

    // next run clears the fault and completes
    run_instr(mk_ir(5'b00011, 4'd1, 4'd2, 4'd3), 0, 1, 20);
    chk("clr_fault_k1", 32'(fault_log[1]), 32'h0);
    chk("clr_done_at", 32'(done_at), 32'd7);

    // mem_ready stuck low
    run_instr(mk_ir(5'b00011, 4'd1, 4'd2, 4'd3), 1000, 1, 30);
    chk("to_fault_at", 32'(fault_at), 32'd18);
    chk("to_fault_code", 32'(fault_log[18]), 32'h2);
    chk("to_read_cycles", 32'(read_cnt), 32'd16);
    chk("to_idle_strb", 32'(strb_log[18]), 32'h0);
    chk("to_no_done", 32'(done_at), 32'd0);

    // clear pulsed low in the middle of T4
    run_instr(mk_ir(5'b00011, 4'd1, 4'd2, 4'd3), 0, 1, 5);
    chk("clr_pre_op", 32'(bus.opcode), 32'h03);
    #2;
    clear = 1'b0;
    #1;
    chk("async_strb", 32'(strb_now), 32'h0);
    chk("async_rin_rout", {bus.Rin, bus.Rout}, 32'h0);
    chk("async_op_done_fault", {24'h0, bus.opcode, bus.done, bus.fault}, 32'h0);
    @(posedge Clock);
    #1;
    clear = 1'b1;
    run_instr(mk_ir(5'b00110, 4'd7, 4'd8, 4'd9), 0, 1, 20);
    chk("post_clr_t0", 32'(strb_log[1]), 32'h3C00);
    chk("post_clr_rin", 32'(rin_log[6]), 32'h0080);
    chk("post_clr_done_at", 32'(done_at), 32'd7);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
